decoder_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with three operating modes: direct decode, timed pulse, and auto-scan. It generalises the combinational 3-8 decoder into a clocked chip-select and strobe generator for memory-mapped peripherals and display/LED scanning in the experiment platform. All outputs are registered, and the block is driven from a single clock domain.

---
 rtl/decoder_seq.sv | 139 +++++++++++++
 tb/tb_decoder_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered N-to-2^N one-hot decoder with direct, pulse and scan modes
// Define DECODER_ACTIVE_LOW_EN to drive OP as active-low selects (idle value all ones).
module decoder_seq #(
  parameter int N         = 3,
  parameter int PULSE_LEN = 2,
  parameter int DWELL     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic [N-1:0]      SEL,
  input  logic              LOAD,
  output logic [(1<<N)-1:0] OP,
  output logic [N-1:0]      IDX,
  output logic              VALID,
  output logic              BUSY
);
  localparam int W    = 1 << N;
  localparam int CMAX = (PULSE_LEN > DWELL) ? PULSE_LEN : DWELL;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] PULSE_RELOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] DWELL_RELOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [N-1:0]  IDX_ONE      = N'(1);
  localparam logic [W-1:0]  OP_ONE       = W'(1);

  typedef enum logic [2:0] {IDLE, DIRECT, PULSE, SCAN, HOLD} state_t;

  state_t        state, state_d;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [W-1:0]  op_q, op_d;
  logic [N-1:0]  idx_out_d;
  logic          valid_d, busy_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      mode_q <= 2'b00;
      cnt    <= '0;
      idx_q  <= '0;
      op_q   <= '0;
      IDX    <= '0;
      VALID  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_d;
      mode_q <= MODE;
      cnt    <= cnt_d;
      idx_q  <= idx_d;
      op_q   <= op_d;
      IDX    <= idx_out_d;
      VALID  <= valid_d;
      BUSY   <= busy_d;
    end
  end

  // Disable or any mode change always lands in IDLE first, giving one zero cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx_q;
    if (!EN || (MODE != mode_q)) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (MODE)
        2'b00: begin
          state_d = DIRECT;
          idx_d   = SEL;
          cnt_d   = '0;
        end
        2'b01: begin
          if (state == PULSE) begin
            if (cnt == '0) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              cnt_d = cnt - CNT_ONE;
            end
          end else if (LOAD) begin
            state_d = PULSE;
            idx_d   = SEL;
            cnt_d   = PULSE_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end
        2'b10: begin
          if (state == SCAN) begin
            if (cnt == '0) begin
              idx_d = idx_q + IDX_ONE;
              cnt_d = DWELL_RELOAD;
            end else begin
              cnt_d = cnt - CNT_ONE;
            end
          end else begin
            state_d = SCAN;
            idx_d   = SEL;
            cnt_d   = DWELL_RELOAD;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_comb begin
    op_d      = '0;
    idx_out_d = '0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    case (state_d)
      DIRECT, PULSE, SCAN: begin
        op_d      = OP_ONE << idx_d;
        idx_out_d = idx_d;
        valid_d   = 1'b1;
        busy_d    = (state_d != DIRECT);
      end
      HOLD: begin
        op_d      = op_q;
        idx_out_d = IDX;
        valid_d   = VALID;
        busy_d    = BUSY;
      end
      default: ;
    endcase
  end

`ifdef DECODER_ACTIVE_LOW_EN
  assign OP = ~op_q;
`else
  assign OP = op_q;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - scoreboard bench for decoder_seq against a behavioural model
module tb_decoder_seq;
  localparam int N         = 3;
  localparam int PULSE_LEN = 2;
  localparam int DWELL     = 4;
  localparam int W         = 1 << N;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         en   = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] sel  = '0;
  logic         load = 1'b0;
  logic [W-1:0] op;
  logic [N-1:0] idx;
  logic         valid;
  logic         busy;

  decoder_seq #(.N(N), .PULSE_LEN(PULSE_LEN), .DWELL(DWELL)) dut (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .SEL(sel), .LOAD(load),
    .OP(op), .IDX(idx), .VALID(valid), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] op;
    logic [N-1:0] idx;
    logic         valid;
    logic         busy;
  } resp_t;

  resp_t sb[$];
  string tag_q[$];
  string phase = "reset";
  int    vectors = 0;
  int    miscompares = 0;

  // Model: what is being shown, and how many edges it has been running.
  typedef enum {M_NONE, M_DIRECT, M_PULSE, M_SCAN, M_HOLD} act_t;
  act_t  m_act   = M_NONE;
  int    m_prev  = 0;
  int    m_cur   = 0;
  int    m_age   = 0;
  int    m_start = 0;
  resp_t m_last  = '0;

  task automatic model_step(input logic r, input logic e, input logic [1:0] md,
                            input logic [N-1:0] s, input logic ld);
    resp_t nxt;
    if (r) begin
      m_act  = M_NONE;
      m_prev = 0;
    end else if (!e || int'(md) != m_prev) begin
      m_act  = M_NONE;
      m_prev = int'(md);
    end else begin
      case (md)
        2'd0: begin
          m_act = M_DIRECT;
          m_cur = int'(s);
        end
        2'd1: begin
          if (m_act == M_PULSE) begin
            m_age++;
            if (m_age >= PULSE_LEN) m_act = M_NONE;
          end else if (ld) begin
            m_act = M_PULSE;
            m_cur = int'(s);
            m_age = 0;
          end
        end
        2'd2: begin
          if (m_act != M_SCAN) begin
            m_act   = M_SCAN;
            m_start = int'(s);
            m_age   = 0;
          end else begin
            m_age++;
          end
          m_cur = (m_start + m_age / DWELL) % W;
        end
        default: m_act = M_HOLD;
      endcase
    end
    if (m_act == M_HOLD) nxt = m_last;
    else if (m_act == M_NONE) nxt = '0;
    else begin
      nxt.op    = W'(1) << m_cur;
      nxt.idx   = N'(m_cur);
      nxt.valid = 1'b1;
      nxt.busy  = (m_act != M_DIRECT);
    end
    m_last = nxt;
`ifdef DECODER_ACTIVE_LOW_EN
    nxt.op = ~nxt.op;
`endif
    sb.push_back(nxt);
    tag_q.push_back(phase);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic [N-1:0] s, input logic ld);
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = md;
    sel  = s;
    load = ld;
    model_step(r, e, md, s, ld);
  endtask

  initial begin : monitor
    resp_t exp_r;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_r = sb.pop_front();
        t     = tag_q.pop_front();
        vectors++;
        if ({op, idx, valid, busy} !== exp_r) begin
          miscompares++;
          $display("FAIL %s @%0t: got op=%h idx=%0d valid=%b busy=%b, expected op=%h idx=%0d valid=%b busy=%b",
                   t, $time, op, idx, valid, busy, exp_r.op, exp_r.idx, exp_r.valid, exp_r.busy);
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0] cm;
    int         waited;
    phase = "reset";
    repeat (2) drive(1'b1, 1'b0, 2'b00, '0, 1'b0);

    phase = "direct";
    drive(1'b0, 1'b1, 2'b00, 3'd5, 1'b0);
    for (int i = 0; i < W; i++) drive(1'b0, 1'b1, 2'b00, N'(i), 1'b0);

    phase = "pulse";
    drive(1'b0, 1'b1, 2'b01, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 3'd3, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 3'd6, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 3'd6, 1'b1);
    repeat (3) drive(1'b0, 1'b1, 2'b01, 3'd1, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 3'd7, 1'b1);
    repeat (3) drive(1'b0, 1'b1, 2'b01, 3'd0, 1'b0);

    phase = "scan_wrap";
    drive(1'b0, 1'b1, 2'b10, 3'd6, 1'b0);
    for (int i = 0; i < 14; i++) drive(1'b0, 1'b1, 2'b10, 3'($urandom), 1'b0);

    phase = "abort_en";
    drive(1'b0, 1'b0, 2'b10, 3'd1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 2'b10, 3'd1, 1'b0);

    phase = "abort_mode";
    repeat (3) drive(1'b0, 1'b1, 2'b00, 3'd2, 1'b0);

    phase = "reset_mid_pulse";
    drive(1'b0, 1'b1, 2'b01, 3'd4, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 3'd4, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 3'd4, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 3'd2, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 3'd2, 1'b1);
    repeat (4) drive(1'b0, 1'b1, 2'b01, 3'd2, 1'b0);

    phase = "hold";
    repeat (4) drive(1'b0, 1'b1, 2'b11, 3'($urandom), 1'b1);

    phase = "random";
    cm = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) cm = 2'($urandom_range(3));
      drive(($urandom_range(99) == 0), ($urandom_range(24) != 0), cm,
            3'($urandom), ($urandom_range(3) == 0));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d responses pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
